// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU control sequencer: states, instruction
// classes, ALU opcodes, branch conditions and datapath mux selects.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StWb,
    StBr,
    StAddr,
    StMemRd,
    StMemWr,
    StWbLd,
    StHalted,
    StFault
  } state_e;

  // Instruction class, IROut[31:30]
  localparam logic [1:0] CLS_R   = 2'b00;
  localparam logic [1:0] CLS_MEM = 2'b01;
  localparam logic [1:0] CLS_BR  = 2'b10;
  localparam logic [1:0] CLS_I   = 2'b11;

  localparam logic [5:0] ALU_ADD = 6'b000010;
  localparam logic [5:0] ALU_SUB = 6'b000011;
  localparam logic [5:0] OP_HALT = 6'b111111;

  // Branch condition, IROut[29:26]
  localparam logic [3:0] BR_BEQ = 4'b0000;
  localparam logic [3:0] BR_BNE = 4'b0001;
  localparam logic [3:0] BR_JMP = 4'b1111;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that wait on the shared memory port and are guarded by the timer
  function automatic logic is_wait_state(input state_e s);
    return (s == StFetch) || (s == StMemRd) || (s == StMemWr);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on memory and flags the cycle on which the wait
// would reach MEM_TIMEOUT. MEM_TIMEOUT of 0 disables expiry.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // i_enable already implies mem_ready is low, so a completing access never expires
  generate
    if (MEM_TIMEOUT == 0) begin : g_no_timeout
      assign o_expired = 1'b0;
    end else begin : g_timeout
      localparam logic [CNT_W-1:0] LastCnt = CNT_W'(MEM_TIMEOUT - 1);
      assign o_expired = i_enable && (r_count == LastCnt);
    end
  endgenerate

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control sequencer: fetch/decode/execute/memory/writeback with a memory
// timeout fault. Define PERF_CNT_EN to build the retired-instruction counter.
module multicycle_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] IROut,
  input  logic        ZeroFlag,
  input  logic        mem_ready,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IorD,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSrc,
  output logic        RegDst,
  output logic        MemToReg,
  output logic [5:0]  ALUOp,
  output logic        fault,
  output logic [31:0] retired_cnt
);

  state_e     r_state;
  state_e     w_state_next;
  logic       w_retire;
  logic       w_wait_en;
  logic       w_clear;
  logic       w_expired;
  logic [1:0] w_cls;
  logic [5:0] w_opcode;
  logic [3:0] w_cond;
  logic       w_is_store;
  logic       w_unused_ir;

  assign w_cls       = IROut[31:30];
  assign w_opcode    = IROut[31:26];
  assign w_cond      = IROut[29:26];
  assign w_is_store  = IROut[26];
  assign w_unused_ir = ^IROut[25:6];

  // Any state change restarts the wait count, covering every entry into a wait state
  assign w_wait_en = is_wait_state(r_state) && !mem_ready;
  assign w_clear   = (w_state_next != r_state);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) u_mem_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_clear),
    .i_enable (w_wait_en),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_retire     = 1'b0;
    IRWrite      = 1'b0;
    PCWrite      = 1'b0;
    RegWrite     = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IorD         = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = SRCB_REGB;
    PCSrc        = PCSRC_ALU;
    RegDst       = 1'b0;
    MemToReg     = 1'b0;
    ALUOp        = ALU_ADD;

    unique case (r_state)
      StIdle: w_state_next = StFetch;

      StFetch: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        if (mem_ready) begin
          IRWrite      = 1'b1;
          PCWrite      = 1'b1;
          w_state_next = StDecode;
        end else if (w_expired) begin
          w_state_next = StFault;
        end
      end

      // Precompute the branch target into ALUOut while the class is decoded
      StDecode: begin
        ALUSrcB = SRCB_IMM_SH2;
        unique case (w_cls)
          CLS_R:   w_state_next = StExec;
          CLS_BR:  w_state_next = StBr;
          CLS_MEM: w_state_next = StAddr;
          CLS_I: begin
            if (w_opcode == OP_HALT) begin
              w_state_next = StHalted;
              w_retire     = 1'b1;
            end else begin
              w_state_next = StExec;
            end
          end
          default: w_state_next = StExec;
        endcase
      end

      StExec: begin
        ALUSrcA = 1'b1;
        if (w_cls == CLS_R) begin
          ALUSrcB = SRCB_REGB;
          ALUOp   = IROut[5:0];
        end else begin
          ALUSrcB = SRCB_IMM;
          ALUOp   = w_opcode;
        end
        w_state_next = StWb;
      end

      StWb: begin
        RegWrite     = 1'b1;
        RegDst       = (w_cls == CLS_R);
        w_retire     = 1'b1;
        w_state_next = StFetch;
      end

      StBr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_REGB;
        ALUOp   = ALU_SUB;
        unique case (w_cond)
          BR_BEQ: begin
            PCWrite = ZeroFlag;
            PCSrc   = PCSRC_ALUOUT;
          end
          BR_BNE: begin
            PCWrite = !ZeroFlag;
            PCSrc   = PCSRC_ALUOUT;
          end
          BR_JMP: begin
            PCWrite = 1'b1;
            PCSrc   = PCSRC_JUMP;
          end
          default: PCWrite = 1'b0;
        endcase
        w_retire     = 1'b1;
        w_state_next = StFetch;
      end

      StAddr: begin
        ALUSrcA      = 1'b1;
        ALUSrcB      = SRCB_IMM;
        w_state_next = w_is_store ? StMemWr : StMemRd;
      end

      StMemRd: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) begin
          w_state_next = StWbLd;
        end else if (w_expired) begin
          w_state_next = StFault;
        end
      end

      StMemWr: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) begin
          w_retire     = 1'b1;
          w_state_next = StFetch;
        end else if (w_expired) begin
          w_state_next = StFault;
        end
      end

      StWbLd: begin
        RegWrite     = 1'b1;
        MemToReg     = 1'b1;
        w_retire     = 1'b1;
        w_state_next = StFetch;
      end

      StHalted: w_state_next = StHalted;
      StFault:  w_state_next = StFault;
      default:  w_state_next = StIdle;
    endcase
  end

  assign fault = (r_state == StFault);

`ifdef PERF_CNT_EN
  logic [31:0] r_retired_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired_cnt <= 32'd0;
    end else if (w_retire) begin
      r_retired_cnt <= r_retired_cnt + 32'd1;
    end
  end

  assign retired_cnt = r_retired_cnt;
`else
  logic w_unused_retire;
  assign w_unused_retire = w_retire;
  assign retired_cnt     = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: per-cycle expected control words are
// queued alongside stimulus and compared as each state executes.
module tb_multicycle_ctrl_fsm;

  localparam int unsigned TIMEOUT = 4;
  localparam logic [5:0]  OP_ADD  = 6'b000010;
  localparam logic [5:0]  OP_SUB  = 6'b000011;

  localparam logic [31:0] IR_ADDI  = 32'hC800_0005;
  localparam logic [31:0] IR_RADD  = 32'h0000_0020;
  localparam logic [31:0] IR_BEQ   = 32'h8000_0000;
  localparam logic [31:0] IR_BNE   = 32'h8400_0000;
  localparam logic [31:0] IR_JMP   = 32'hBC00_0000;
  localparam logic [31:0] IR_BNOP  = 32'h9400_0000;
  localparam logic [31:0] IR_LOAD  = 32'h4000_0000;
  localparam logic [31:0] IR_STORE = 32'h4400_0000;
  localparam logic [31:0] IR_HALT  = 32'hFC00_0000;

  typedef struct packed {
    logic       irw, pcw, rw, mr, mw, iord, srca;
    logic [1:0] srcb, pcsrc;
    logic       rd, m2r;
    logic [5:0] op;
    logic       flt;
  } ctl_t;

  typedef struct {
    logic [31:0] ir;
    logic        rdy;
    logic        zf;
  } stim_t;

  localparam ctl_t C_IDLE      = ctl_t'{op: OP_ADD, default: '0};
  localparam ctl_t C_FETCH     = ctl_t'{irw: 1'b1, pcw: 1'b1, mr: 1'b1, srcb: 2'b01, op: OP_ADD,
                                         default: '0};
  localparam ctl_t C_FETCH_W   = ctl_t'{mr: 1'b1, srcb: 2'b01, op: OP_ADD, default: '0};
  localparam ctl_t C_DECODE    = ctl_t'{srcb: 2'b11, op: OP_ADD, default: '0};
  localparam ctl_t C_EXEC_ADDI = ctl_t'{srca: 1'b1, srcb: 2'b10, op: 6'b110010, default: '0};
  localparam ctl_t C_EXEC_RADD = ctl_t'{srca: 1'b1, srcb: 2'b00, op: 6'b100000, default: '0};
  localparam ctl_t C_WB_I      = ctl_t'{rw: 1'b1, op: OP_ADD, default: '0};
  localparam ctl_t C_WB_R      = ctl_t'{rw: 1'b1, rd: 1'b1, op: OP_ADD, default: '0};
  localparam ctl_t C_BR_TAKEN  = ctl_t'{pcw: 1'b1, srca: 1'b1, pcsrc: 2'b01, op: OP_SUB,
                                         default: '0};
  localparam ctl_t C_BR_NOT    = ctl_t'{srca: 1'b1, pcsrc: 2'b01, op: OP_SUB, default: '0};
  localparam ctl_t C_BR_JMP    = ctl_t'{pcw: 1'b1, srca: 1'b1, pcsrc: 2'b10, op: OP_SUB,
                                         default: '0};
  localparam ctl_t C_BR_NOP    = ctl_t'{srca: 1'b1, op: OP_SUB, default: '0};
  localparam ctl_t C_ADDR      = ctl_t'{srca: 1'b1, srcb: 2'b10, op: OP_ADD, default: '0};
  localparam ctl_t C_MEMRD     = ctl_t'{mr: 1'b1, iord: 1'b1, op: OP_ADD, default: '0};
  localparam ctl_t C_MEMWR     = ctl_t'{mw: 1'b1, iord: 1'b1, op: OP_ADD, default: '0};
  localparam ctl_t C_WBLD      = ctl_t'{rw: 1'b1, m2r: 1'b1, op: OP_ADD, default: '0};
  localparam ctl_t C_FAULT     = ctl_t'{flt: 1'b1, op: OP_ADD, default: '0};

  logic        clk;
  logic        rst_n;
  logic [31:0] IROut;
  logic        ZeroFlag;
  logic        mem_ready;
  logic        IRWrite, PCWrite, RegWrite, MemRead, MemWrite, IorD, ALUSrcA;
  logic [1:0]  ALUSrcB, PCSrc;
  logic        RegDst, MemToReg;
  logic [5:0]  ALUOp;
  logic        fault;
  logic [31:0] retired_cnt;

  ctl_t        w_obs;
  ctl_t        exp_q[$];
  stim_t       stim_q[$];
  int          n_pass;
  int          n_chk;
  int unsigned exp_ret;

  multicycle_ctrl_fsm #(
    .MEM_TIMEOUT(TIMEOUT),
    .CNT_W      (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .IROut      (IROut),
    .ZeroFlag   (ZeroFlag),
    .mem_ready  (mem_ready),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .RegWrite   (RegWrite),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .IorD       (IorD),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .PCSrc      (PCSrc),
    .RegDst     (RegDst),
    .MemToReg   (MemToReg),
    .ALUOp      (ALUOp),
    .fault      (fault),
    .retired_cnt(retired_cnt)
  );

  assign w_obs = {IRWrite, PCWrite, RegWrite, MemRead, MemWrite, IorD, ALUSrcA, ALUSrcB, PCSrc,
                  RegDst, MemToReg, ALUOp, fault};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] exp_cnt();
`ifdef PERF_CNT_EN
    return exp_ret;
`else
    return 32'd0;
`endif
  endfunction

  task automatic push(input logic [31:0] ir, input logic rdy, input logic zf, input ctl_t e);
    stim_t s;
    s.ir  = ir;
    s.rdy = rdy;
    s.zf  = zf;
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic push_fd(input logic [31:0] ir);
    push(ir, 1'b1, 1'b0, C_FETCH);
    push(ir, 1'b1, 1'b0, C_DECODE);
  endtask

  task automatic test_reset();
    #1;
    n_chk++;
    if (w_obs !== C_IDLE) $display("FAIL reset ctl: got %h want %h", w_obs, C_IDLE);
    else n_pass++;
    n_chk++;
    if (retired_cnt !== 32'd0) $display("FAIL reset retired_cnt: got %0d want 0", retired_cnt);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_alu();
    stim_t s;
    ctl_t  e;
    int    k;
    push(IR_ADDI, 1'b1, 1'b0, C_IDLE);
    push_fd(IR_ADDI);
    push(IR_ADDI, 1'b1, 1'b0, C_EXEC_ADDI);
    push(IR_ADDI, 1'b1, 1'b0, C_WB_I);
    push_fd(IR_RADD);
    push(IR_RADD, 1'b1, 1'b0, C_EXEC_RADD);
    push(IR_RADD, 1'b1, 1'b0, C_WB_R);
    exp_ret += 2;
    k = 0;
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      IROut = s.ir; mem_ready = s.rdy; ZeroFlag = s.zf;
      @(negedge clk);
      n_chk++;
      if (w_obs !== e) $display("FAIL alu cycle %0d ctl: got %h want %h", k, w_obs, e);
      else n_pass++;
      k++;
      @(posedge clk); #1;
    end
    n_chk++;
    if (retired_cnt !== exp_cnt())
      $display("FAIL alu retired_cnt: got %0d want %0d", retired_cnt, exp_cnt());
    else n_pass++;
  endtask

  task automatic test_branch();
    stim_t s;
    ctl_t  e;
    int    k;
    push_fd(IR_BEQ);  push(IR_BEQ,  1'b1, 1'b1, C_BR_TAKEN);
    push_fd(IR_BEQ);  push(IR_BEQ,  1'b1, 1'b0, C_BR_NOT);
    push_fd(IR_BNE);  push(IR_BNE,  1'b1, 1'b0, C_BR_TAKEN);
    push_fd(IR_JMP);  push(IR_JMP,  1'b1, 1'b0, C_BR_JMP);
    push_fd(IR_BNOP); push(IR_BNOP, 1'b1, 1'b1, C_BR_NOP);
    exp_ret += 5;
    k = 0;
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      IROut = s.ir; mem_ready = s.rdy; ZeroFlag = s.zf;
      @(negedge clk);
      n_chk++;
      if (w_obs !== e) $display("FAIL branch cycle %0d ctl: got %h want %h", k, w_obs, e);
      else n_pass++;
      k++;
      @(posedge clk); #1;
    end
    n_chk++;
    if (retired_cnt !== exp_cnt())
      $display("FAIL branch retired_cnt: got %0d want %0d", retired_cnt, exp_cnt());
    else n_pass++;
  endtask

  task automatic test_load_store();
    stim_t s;
    ctl_t  e;
    int    k;
    push_fd(IR_LOAD);
    push(IR_LOAD, 1'b1, 1'b0, C_ADDR);
    // Three stalled cycles leave the counter one short of the timeout
    for (int i = 0; i < 3; i++) push(IR_LOAD, 1'b0, 1'b0, C_MEMRD);
    push(IR_LOAD, 1'b1, 1'b0, C_MEMRD);
    push(IR_LOAD, 1'b1, 1'b0, C_WBLD);
    push_fd(IR_STORE);
    push(IR_STORE, 1'b1, 1'b0, C_ADDR);
    push(IR_STORE, 1'b1, 1'b0, C_MEMWR);
    exp_ret += 2;
    k = 0;
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      IROut = s.ir; mem_ready = s.rdy; ZeroFlag = s.zf;
      @(negedge clk);
      n_chk++;
      if (w_obs !== e) $display("FAIL ldst cycle %0d ctl: got %h want %h", k, w_obs, e);
      else n_pass++;
      k++;
      @(posedge clk); #1;
    end
    n_chk++;
    if (retired_cnt !== exp_cnt())
      $display("FAIL ldst retired_cnt: got %0d want %0d", retired_cnt, exp_cnt());
    else n_pass++;
  endtask

  task automatic test_timeout();
    stim_t s;
    ctl_t  e;
    int    k;
    for (int i = 0; i < TIMEOUT; i++) push(IR_ADDI, 1'b0, 1'b0, C_FETCH_W);
    for (int i = 0; i < 3; i++) push(IR_ADDI, 1'b1, 1'b0, C_FAULT);
    k = 0;
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      IROut = s.ir; mem_ready = s.rdy; ZeroFlag = s.zf;
      @(negedge clk);
      n_chk++;
      if (w_obs !== e) $display("FAIL timeout cycle %0d ctl: got %h want %h", k, w_obs, e);
      else n_pass++;
      k++;
      @(posedge clk); #1;
    end
    n_chk++;
    if (retired_cnt !== exp_cnt())
      $display("FAIL timeout retired_cnt: got %0d want %0d", retired_cnt, exp_cnt());
    else n_pass++;
    rst_n = 1'b0;
    exp_ret = 0;
    #1;
    n_chk++;
    if (w_obs !== C_IDLE) $display("FAIL timeout reset ctl: got %h want %h", w_obs, C_IDLE);
    else n_pass++;
    n_chk++;
    if (retired_cnt !== 32'd0)
      $display("FAIL timeout reset retired_cnt: got %0d want 0", retired_cnt);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_write();
    stim_t s;
    ctl_t  e;
    int    k;
    push(IR_STORE, 1'b1, 1'b0, C_IDLE);
    push_fd(IR_STORE);
    push(IR_STORE, 1'b1, 1'b0, C_ADDR);
    push(IR_STORE, 1'b0, 1'b0, C_MEMWR);
    k = 0;
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      IROut = s.ir; mem_ready = s.rdy; ZeroFlag = s.zf;
      @(negedge clk);
      n_chk++;
      if (w_obs !== e) $display("FAIL midwr cycle %0d ctl: got %h want %h", k, w_obs, e);
      else n_pass++;
      k++;
      @(posedge clk); #1;
    end
    n_chk++;
    if (MemWrite !== 1'b1) $display("FAIL midwr MemWrite before reset: got %b want 1", MemWrite);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (MemWrite !== 1'b0) $display("FAIL midwr MemWrite in reset: got %b want 0", MemWrite);
    else n_pass++;
    n_chk++;
    if (w_obs !== C_IDLE) $display("FAIL midwr reset ctl: got %h want %h", w_obs, C_IDLE);
    else n_pass++;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_chk++;
    if (retired_cnt !== 32'd0) $display("FAIL midwr retired_cnt: got %0d want 0", retired_cnt);
    else n_pass++;
  endtask

  task automatic test_halt_count();
    stim_t s;
    ctl_t  e;
    int    k;
    push(IR_ADDI, 1'b1, 1'b0, C_IDLE);
    push_fd(IR_ADDI);
    push(IR_ADDI, 1'b1, 1'b0, C_EXEC_ADDI);
    push(IR_ADDI, 1'b1, 1'b0, C_WB_I);
    push_fd(IR_BEQ);
    push(IR_BEQ, 1'b1, 1'b1, C_BR_TAKEN);
    push_fd(IR_STORE);
    push(IR_STORE, 1'b1, 1'b0, C_ADDR);
    push(IR_STORE, 1'b1, 1'b0, C_MEMWR);
    push_fd(IR_HALT);
    for (int i = 0; i < 5; i++) push(IR_HALT, i[0], 1'b0, C_IDLE);
    exp_ret = 4;
    k = 0;
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      IROut = s.ir; mem_ready = s.rdy; ZeroFlag = s.zf;
      @(negedge clk);
      n_chk++;
      if (w_obs !== e) $display("FAIL halt cycle %0d ctl: got %h want %h", k, w_obs, e);
      else n_pass++;
      k++;
      @(posedge clk); #1;
    end
    n_chk++;
    if (retired_cnt !== exp_cnt())
      $display("FAIL halt retired_cnt: got %0d want %0d", retired_cnt, exp_cnt());
    else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (retired_cnt !== exp_cnt())
      $display("FAIL halt retired_cnt hold: got %0d want %0d", retired_cnt, exp_cnt());
    else n_pass++;
  endtask

  initial begin
    n_pass    = 0;
    n_chk     = 0;
    exp_ret   = 0;
    rst_n     = 1'b1;
    IROut     = 32'd0;
    ZeroFlag  = 1'b0;
    mem_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    test_reset();
    test_alu();
    test_branch();
    test_load_store();
    test_timeout();
    test_reset_mid_write();
    test_halt_count();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
